wrr_arbiter: RTL and testbench
==============================

# wrr_arbiter

Parametrised weighted round-robin arbiter with registered one-hot grants and per-requester burst credits. It is the successor to the team's fixed 4-way round-robin arbiter. A winner keeps the grant for up to its programmed weight of consecutive cycles, then priority rotates past it. It sits in front of shared resources (bus ports, memory banks) wherever unequal bandwidth shares are needed.

## Interface
- REQS, 4, number of requesters; legal range 2..32; need not be a power of two
- WEIGHT_W, 3, width of each requester's weight field
- IDX_W, $clog2(REQS), derived localparam; width of the winner index
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- reqs_i  in  REQS  request vector; bit i = requester i wants the resource
- weights_i  in  REQS*WEIGHT_W  burst length per requester; field i is bits [i*WEIGHT_W +: WEIGHT_W]; value 0 is treated as 1
- grants_o  out  REQS  registered one-hot grant, or all zeros
- any_grant_o  out  1  registered; equals |grants_o
- grant_idx_o  out  IDX_W  registered index of the current owner; holds its last value when no grant is active
- lock_i  in  1  present only with WRR_LOCK_EN (see Configuration)

## Operation
- State registers:
  - ptr: priority pointer, the first index searched.
  - owner, valid: current grant holder and whether a grant is active.
  - credit: remaining grant cycles for the owner, width WEIGHT_W.
- Two states:
  - IDLE (valid=0).
  - BUSY (valid=1, owner holds the grant).
- Winner search: take the first i with reqs_i[i]=1, scanning ptr, ptr+1, … REQS-1, 0, … ptr-1. Wrap is done by compare against REQS, not by bit overflow, so non-power-of-two REQS works.
- IDLE, at each edge:
  - If any request is set, grant the search winner w: owner=w, credit=max(weights_i[w],1)-1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, at each edge, the owner continues if reqs_i[owner]=1 and credit≠0:
  - Keep the grant and decrement credit.
  - Changes to weights_i mid-burst are ignored; the weight is latched at grant.
- BUSY, at each edge, otherwise the owner releases:
  - ptr = (owner+1) mod REQS.
  - Re-run the search in the same cycle with the new ptr on the current reqs_i. There is no idle bubble between owners.
  - If the old owner is the only requester, it is re-granted with fresh credit.
  - If nothing is requested, go to IDLE: grants_o=0 and any_grant_o=0.
- grants_o is never multi-hot. A grant is never issued to a requester whose reqs_i bit was 0 at the sampling edge.
- The pointer moves only on release, never on an idle cycle.

## Timing
- Latency: reqs_i sampled at edge n gives grants_o valid after edge n and stable until edge n+1. There are no combinational paths from input to output.
- A burst of weight W lasts exactly W cycles if the request stays high.
- A request drop at edge n ends the grant after edge n, independent of remaining credit.
- Reset values: grants_o=0, any_grant_o=0, grant_idx_o=0, ptr=0, credit=0, state IDLE.
- Reset asserted mid-burst clears the grant immediately (asynchronously). After deassertion, priority restarts at index 0.
- Requests arriving in the first edge after reset deassertion are arbitrated normally.

## Configuration
- WRR_LOCK_EN defined:
  - Adds the lock_i port.
  - While lock_i=1 and the owner's request is high, the owner keeps the grant regardless of credit, and credit does not decrement.
  - When lock_i falls, normal credit rules resume with the remaining credit.
  - lock_i has no effect in IDLE.
- WRR_LOCK_EN undefined: no lock_i port; behaviour is exactly as above.

## Structure
- Package wrr_arbiter_pkg holds:
  - the state enum (IDLE, BUSY);
  - a function next_idx(idx, reqs) returning (idx+1) mod REQS.
- Sub-module wrr_pick_first: purely combinational rotating-priority search.
  - Inputs: reqs, ptr.
  - Outputs: found, idx.
  - Instantiated once in wrr_arbiter.

## Test plan
All scenarios use REQS=4, WEIGHT_W=3.
- Reset then reqs_i=4'b0000 for 3 cycles -> grants_o=0, any_grant_o=0, grant_idx_o=0.
- weights all 1, reqs_i=4'b1111 held 8 cycles -> grants 0001,0010,0100,1000 repeated twice; any_grant_o=1 throughout.
- weights={1,1,1,3} (req0 weight 3), reqs_i=4'b0101 -> grant sequence 0001×3, 0100×1, 0001×3, …
- Weight 3 on req0 and req0 drops after 1 granted cycle while reqs_i[2]=1 -> next cycle grants_o=0100, no bubble.
- Async rst pulse mid-burst with reqs_i=4'b1010 -> grants_o=0 immediately. First grant after release is 0010 (index 1, ptr=0).
- With WRR_LOCK_EN: owner 2, weight 1, lock_i=1 for 5 cycles with reqs_i=4'b1111 -> 0100 held 5 cycles, then 1000.

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Wraps by comparing against the requester count, so non-power-of-two REQS is safe.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned reqs);
    return (idx + 1 >= reqs) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wrr_pick_first.sv
// Rotating-priority search: first requester at or after ptr, wrapping at REQS.
module wrr_pick_first
  import wrr_arbiter_pkg::*;
#(
  parameter int REQS  = 4,
  parameter int IDX_W = 2
) (
  input  logic [REQS-1:0]  reqs,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int unsigned c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int unsigned k = 0; k < REQS; k++) begin
      c = 32'(ptr) + k;
      if (c >= REQS) c = c - REQS;
      if (!found && reqs[c[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grants and burst credits.
// Optional WRR_LOCK_EN adds lock_i, which holds the owner's grant without spending credit.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int REQS     = 4,
  parameter int WEIGHT_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQS-1:0]          reqs_i,
  input  logic [REQS*WEIGHT_W-1:0] weights_i,
`ifdef WRR_LOCK_EN
  input  logic                     lock_i,
`endif
  output logic [REQS-1:0]          grants_o,
  output logic                     any_grant_o,
  output logic [$clog2(REQS)-1:0]  grant_idx_o
);

  localparam int IDX_W = $clog2(REQS);

  state_e              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    owner_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic [REQS-1:0]     grants_q;
  logic                any_q;

  logic                lock_w;
  logic                keep;
  logic [IDX_W-1:0]    search_ptr;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [WEIGHT_W-1:0] win_weight;
  logic [WEIGHT_W-1:0] credit_load;
  logic [REQS-1:0]     grant_vec;

`ifdef WRR_LOCK_EN
  assign lock_w = lock_i;
`else
  assign lock_w = 1'b0;
`endif

  // On release the search starts past the old owner in the same cycle, so there is no bubble.
  always_comb begin
    keep        = (state_q == BUSY) && reqs_i[owner_q] && ((credit_q != '0) || lock_w);
    search_ptr  = (state_q == BUSY) ? IDX_W'(next_idx(32'(owner_q), REQS)) : ptr_q;
    win_weight  = weights_i[32'(pick_idx)*WEIGHT_W +: WEIGHT_W];
    credit_load = (win_weight == '0) ? '0 : win_weight - WEIGHT_W'(1);
    grant_vec   = REQS'(1) << pick_idx;
  end

  wrr_pick_first #(
    .REQS  (REQS),
    .IDX_W (IDX_W)
  ) u_pick (
    .reqs  (reqs_i),
    .ptr   (search_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
      grants_q <= '0;
      any_q    <= 1'b0;
    end else if (keep) begin
      if (!lock_w) credit_q <= credit_q - WEIGHT_W'(1);
    end else begin
      if (state_q == BUSY) ptr_q <= search_ptr;
      if (pick_found) begin
        state_q  <= BUSY;
        owner_q  <= pick_idx;
        credit_q <= credit_load;
        grants_q <= grant_vec;
        any_q    <= 1'b1;
      end else begin
        state_q  <= IDLE;
        grants_q <= '0;
        any_q    <= 1'b0;
      end
    end
  end

  assign grants_o    = grants_q;
  assign any_grant_o = any_q;
  assign grant_idx_o = owner_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: per-cycle reference model plus directed literal checks.
module tb_wrr_arbiter;

  localparam int REQS     = 4;
  localparam int WEIGHT_W = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  reqs = 4'b0000;
  logic [11:0] weights = 12'b001_001_001_001;
  logic        lock = 1'b0;
  logic [3:0]  grants;
  logic        any;
  logic [1:0]  idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(
    .REQS     (REQS),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reqs_i      (reqs),
    .weights_i   (weights),
`ifdef WRR_LOCK_EN
    .lock_i      (lock),
`endif
    .grants_o    (grants),
    .any_grant_o (any),
    .grant_idx_o (idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks cycles already granted against the weight latched at grant time.
  bit m_valid;
  int m_owner, m_ptr, m_used, m_w;

  function automatic int wt(input int c);
    logic [11:0] w;
    w = weights;
    return int'(w[c*WEIGHT_W +: WEIGHT_W]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_owner = 0; m_ptr = 0; m_used = 0; m_w = 0;
    end else if (m_valid && reqs[m_owner] && (m_used < m_w || lock)) begin
      if (!lock) m_used = m_used + 1;
    end else begin
      bit found;
      int c;
      found = 1'b0;
      if (m_valid) m_ptr = (m_owner + 1) % REQS;
      for (int k = 0; k < REQS; k++) begin
        c = (m_ptr + k) % REQS;
        if (!found && reqs[c]) begin
          found   = 1'b1;
          m_owner = c;
        end
      end
      if (found) begin
        m_valid = 1'b1;
        m_used  = 1;
        m_w     = (wt(m_owner) == 0) ? 1 : wt(m_owner);
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [3:0] e;
      e = m_valid ? (4'b0001 << m_owner) : 4'b0000;
      chk("model_grants", 32'(grants), 32'(e));
      chk("model_any", 32'(any), 32'(m_valid));
      chk("model_idx", 32'(idx), 32'(m_owner));
    end
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] exp, input string name);
    reqs = r;
    @(posedge clk);
    #1;
    chk(name, 32'(grants), 32'(exp));
  endtask

  logic [3:0] seq3 [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100,
                           4'b0001, 4'b0001, 4'b0001, 4'b0100};

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_grants", 32'(grants), 32'h0);
    chk("reset_idx", 32'(idx), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0000, "idle_no_req");
    chk("idle_any", 32'(any), 32'h0);
    chk("idle_idx", 32'(idx), 32'h0);

    for (int i = 0; i < 8; i++) cyc(4'b1111, 4'(1 << (i % 4)), "rr_equal_weights");
    chk("rr_any", 32'(any), 32'h1);
    cyc(4'b0000, 4'b0000, "rr_to_idle");

    weights = {3'd1, 3'd1, 3'd1, 3'd3};
    cyc(4'b0101, seq3[0], "wrr_w3_first");
    for (int i = 1; i < 8; i++) cyc(4'b0101, seq3[i], "wrr_w3_seq");

    cyc(4'b0101, 4'b0001, "drop_grant0");
    cyc(4'b0100, 4'b0100, "drop_no_bubble");
    chk("drop_idx", 32'(idx), 32'h2);
    cyc(4'b0000, 4'b0000, "drop_to_idle");
    chk("idle_idx_hold", 32'(idx), 32'h2);

    weights = {3'd1, 3'd1, 3'd1, 3'd0};
    cyc(4'b0011, 4'b0001, "w0_as_1_a");
    cyc(4'b0011, 4'b0010, "w0_as_1_b");
    cyc(4'b0011, 4'b0001, "w0_as_1_c");
    cyc(4'b0000, 4'b0000, "w0_to_idle");

    weights = {3'd3, 3'd1, 3'd3, 3'd3};
    cyc(4'b1010, 4'b0010, "burst_start");
    cyc(4'b1010, 4'b0010, "burst_hold");
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_grants", 32'(grants), 32'h0);
    chk("async_rst_any", 32'(any), 32'h0);
    chk("async_rst_idx", 32'(idx), 32'h0);
    #3;
    rst = 1'b0;
    cyc(4'b1010, 4'b0010, "after_rst_first");
    chk("after_rst_idx", 32'(idx), 32'h1);
    cyc(4'b0000, 4'b0000, "after_rst_idle");

`ifdef WRR_LOCK_EN
    weights = 12'b001_001_001_001;
    cyc(4'b0100, 4'b0100, "lock_owner2");
    lock = 1'b1;
    for (int i = 0; i < 4; i++) cyc(4'b1111, 4'b0100, "lock_hold");
    lock = 1'b0;
    cyc(4'b1111, 4'b1000, "lock_release");
    cyc(4'b0000, 4'b0000, "lock_idle");
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
